// File: rtl/sprite_compositor_pkg.sv
// Shared definitions for the sprite compositor: default pixel width,
// opaque-flag position and the frame-tracking state encoding.
package sprite_compositor_pkg;

  localparam int PIXEL_SIZE_DEF = 16;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_VSYNC  = 1'b1
  } frame_state_t;

  // The opaque flag is always the top bit of a sprite pixel.
  function automatic int opaque_bit(input int pixel_size);
    return pixel_size - 1;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Video bus between the scan generator / sprite fetch (master) and the
// compositor (slave): sprite layers, background, raw and aligned timing.
interface sprite_compositor_if #(
  parameter int PIXEL_SIZE  = sprite_compositor_pkg::PIXEL_SIZE_DEF,
  parameter int NUM_SPRITES = 4
);

  logic [NUM_SPRITES*PIXEL_SIZE-1:0] sprite_pixel;
  logic [NUM_SPRITES-1:0]            sprite_en;
  logic [PIXEL_SIZE-2:0]             bg_pixel;
  logic                              hsync_in;
  logic                              vsync_in;
  logic                              blank_in;

  logic [PIXEL_SIZE-2:0]             pixel_out;
  logic                              hsync_out;
  logic                              vsync_out;
  logic                              blank_out;
  logic [NUM_SPRITES-1:0]            collision;
  logic                              frame_done;

  modport master (
    output sprite_pixel, sprite_en, bg_pixel, hsync_in, vsync_in, blank_in,
    input  pixel_out, hsync_out, vsync_out, blank_out, collision, frame_done
  );

  modport slave (
    input  sprite_pixel, sprite_en, bg_pixel, hsync_in, vsync_in, blank_in,
    output pixel_out, hsync_out, vsync_out, blank_out, collision, frame_done
  );

endinterface

// File: rtl/sprite_compositor_sync_delay_line.sv
// Fixed-depth shift register with a per-bit reset value; exposes the last
// stage and the stage just before it (the value the output takes next).
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dpre
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

  // With a single stage the "next output value" is the input itself.
  generate
    if (DEPTH > 1) begin : g_deep
      assign dpre = stage_q[DEPTH-2];
    end else begin : g_single
      assign dpre = din;
    end
  endgenerate

endmodule

// File: rtl/sprite_compositor.sv
// Priority sprite compositor: picks the highest-priority opaque layer over
// the background, aligns timing, and reports per-frame sprite collisions.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int PIXEL_SIZE  = PIXEL_SIZE_DEF,
  parameter int NUM_SPRITES = 4,
  parameter int SYNC_DELAY  = 2
) (
  input logic                clk,
  input logic                rst,
  sprite_compositor_if.slave bus
);

  localparam int OPQ = opaque_bit(PIXEL_SIZE);
  localparam int CW  = PIXEL_SIZE - 1;

  logic [2:0]             tim_out;
  logic [2:0]             tim_pre;
  logic                   blank_p0;
  logic                   vsync_pre;
  logic                   hsync_pre_unused;

  logic [NUM_SPRITES-1:0] vis_p0;
  logic [NUM_SPRITES-1:0] hit_p0;
  logic [CW-1:0]          win_p0;
  logic                   seen_p0;
  logic                   multi_p0;

  logic [CW-1:0]          pixel_p1;
  logic                   done_p1;
  logic [NUM_SPRITES-1:0] sticky_q;
  logic [NUM_SPRITES-1:0] collision_q;

  frame_state_t           state_q;
  frame_state_t           state_d;
  logic                   frame_end;
  logic                   vsync_fall;
  logic                   done_d;

  // Timing bits {blank, vsync, hsync}; blank idles high, syncs idle low.
  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (3'b100)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.blank_in, bus.vsync_in, bus.hsync_in}),
    .dout (tim_out),
    .dpre (tim_pre)
  );

  assign bus.hsync_out = tim_out[0];
  assign bus.vsync_out = tim_out[1];
  assign bus.blank_out = tim_out[2];

  // One stage short of the output: lines up with the sprite inputs.
  assign blank_p0         = tim_pre[2];
  assign vsync_pre        = tim_pre[1];
  assign hsync_pre_unused = tim_pre[0];

  // ---- p0: sprite inputs -> visibility, priority winner, overlap ----
  always_comb begin
    vis_p0   = '0;
    win_p0   = bus.bg_pixel;
    seen_p0  = 1'b0;
    multi_p0 = 1'b0;
    // Walk from lowest priority up so the lowest visible index wins.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      vis_p0[i] = bus.sprite_en[i] & bus.sprite_pixel[i*PIXEL_SIZE + OPQ];
      if (vis_p0[i]) begin
        win_p0   = bus.sprite_pixel[i*PIXEL_SIZE +: CW];
        multi_p0 = multi_p0 | seen_p0;
        seen_p0  = 1'b1;
      end
    end
  end

  assign hit_p0 = (multi_p0 && !blank_p0) ? vis_p0 : '0;

  // Frame boundary is the rising edge of vsync as seen at the output.
  assign frame_end  = vsync_pre & ~tim_out[1];
  assign vsync_fall = tim_out[1] & ~vsync_pre;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (frame_end) begin
          state_d = ST_VSYNC;
          done_d  = 1'b1;
        end
      end
      ST_VSYNC: begin
        if (vsync_fall) begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // ---- p1: registered pixel, frame status ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACTIVE;
      pixel_p1    <= '0;
      done_p1     <= 1'b0;
      sticky_q    <= '0;
      collision_q <= '0;
    end else begin
      state_q  <= state_d;
      pixel_p1 <= blank_p0 ? '0 : win_p0;
      done_p1  <= done_d;
      // Hits landing on the closing edge belong to the frame being closed.
      if (done_d) begin
        collision_q <= sticky_q | hit_p0;
        sticky_q    <= '0;
      end else if (state_q == ST_ACTIVE) begin
        sticky_q <= sticky_q | hit_p0;
      end
    end
  end

  assign bus.pixel_out  = pixel_p1;
  assign bus.frame_done = done_p1;
  assign bus.collision  = collision_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a cycle model pushes expected
// outputs per driven pixel, a monitor pops and compares after each edge.
module tb_sprite_compositor;

  localparam int PS = 16;
  localparam int NS = 4;

  logic clk;
  logic rst;

  sprite_compositor_if #(.PIXEL_SIZE(PS), .NUM_SPRITES(NS)) bus ();

  sprite_compositor #(
    .PIXEL_SIZE  (PS),
    .NUM_SPRITES (NS),
    .SYNC_DELAY  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] pix;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fd;
    logic [3:0]  col;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int fd_seen = 0;
  int m_fd_cnt = 0;

  // model state
  logic       m_h1, m_v1, m_b1, m_vout;
  logic [3:0] m_sticky, m_col;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_h1 = 1'b0; m_v1 = 1'b0; m_b1 = 1'b1; m_vout = 1'b0;
    m_sticky = '0; m_col = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel"}, bus.pixel_out, 0);
    check({tag, "_hsync"}, bus.hsync_out, 0);
    check({tag, "_vsync"}, bus.vsync_out, 0);
    check({tag, "_blank"}, bus.blank_out, 1);
    check({tag, "_collision"}, bus.collision, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  function automatic logic [63:0] px4(input logic [15:0] l0, input logic [15:0] l1,
                                      input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Called at a falling edge: drive one pixel, predict the outputs after the
  // next rising edge, then wait for the following falling edge.
  task automatic step(input logic [63:0] px, input logic [3:0] en, input logic [14:0] bg,
                      input logic h, input logic v, input logic b);
    exp_t       e;
    logic [3:0] vis;
    logic [3:0] hit;
    logic [14:0] win;
    int         nvis;
    bit         found;
    bus.sprite_pixel = px;
    bus.sprite_en    = en;
    bus.bg_pixel     = bg;
    bus.hsync_in     = h;
    bus.vsync_in     = v;
    bus.blank_in     = b;
    nvis  = 0;
    found = 0;
    win   = bg;
    for (int i = 0; i < NS; i++) begin
      vis[i] = en[i] & px[i*PS + 15];
      if (vis[i]) begin
        nvis++;
        if (!found) begin
          win   = px[i*PS +: 15];
          found = 1;
        end
      end
    end
    hit   = (nvis >= 2 && !m_b1) ? vis : 4'b0000;
    e.pix = m_b1 ? 15'd0 : win;
    e.hs  = m_h1;
    e.vs  = m_v1;
    e.bl  = m_b1;
    e.fd  = m_v1 & ~m_vout;
    if (e.fd) begin
      m_col    = m_sticky | hit;
      m_sticky = '0;
      m_fd_cnt++;
    end else if (!m_vout) begin
      m_sticky = m_sticky | hit;
    end
    e.col  = m_col;
    m_vout = m_v1;
    m_h1   = h;
    m_v1   = v;
    m_b1   = b;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic v, input logic b);
    for (int i = 0; i < n; i++) step(64'd0, 4'd0, 15'h0155, 1'b0, v, b);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("pixel_out", bus.pixel_out, e.pix);
      check("hsync_out", bus.hsync_out, e.hs);
      check("vsync_out", bus.vsync_out, e.vs);
      check("blank_out", bus.blank_out, e.bl);
      check("frame_done", bus.frame_done, e.fd);
      check("collision", bus.collision, e.col);
      if (bus.frame_done === 1'b1) fd_seen++;
    end
  end

  initial begin
    logic [63:0] rpx;
    logic        rv, rb;
    rst = 1'b1;
    bus.sprite_pixel = '0;
    bus.sprite_en    = '0;
    bus.bg_pixel     = '0;
    bus.hsync_in     = 1'b0;
    bus.vsync_in     = 1'b0;
    bus.blank_in     = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    idle(2, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b0);
    step(64'd0, 4'd0, 15'h0155, 1'b1, 1'b0, 1'b0);

    // two opaque layers overlap: layer 0 wins, layers 0/1 collide
    for (int i = 0; i < 3; i++)
      step(px4(16'h801F, 16'hFC00, 16'h0, 16'h0), 4'b0011, 15'h03E0, 1'b0, 1'b0, 1'b0);
    // layer 0 enabled but transparent, layer 2 opaque alone
    for (int i = 0; i < 3; i++)
      step(px4(16'h001F, 16'h0, 16'h83E0, 16'h0), 4'b0101, 15'h1234, 1'b0, 1'b0, 1'b0);
    // blanked overlap of layers 2/3 must not record a hit
    step(64'd0, 4'd0, 15'h0155, 1'b0, 1'b0, 1'b1);
    step(px4(16'h801F, 16'hFC00, 16'h83E0, 16'h8ABC), 4'b1100, 15'h0155, 1'b0, 1'b0, 1'b1);
    step(px4(16'h801F, 16'hFC00, 16'h83E0, 16'h8ABC), 4'b1100, 15'h0155, 1'b0, 1'b0, 1'b1);
    step(px4(16'h801F, 16'hFC00, 16'h83E0, 16'h8ABC), 4'b1100, 15'h0155, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);

    // long vsync: exactly one frame_done, collision = layers 0/1
    idle(10, 1'b1, 1'b1);
    idle(4, 1'b0, 1'b1);
    check("collision_frame1", bus.collision, 4'b0011);

    // frame with single visible layers only -> collision cleared
    for (int i = 0; i < 8; i++)
      step(px4(16'h8001 + 16'(i), 16'h0, 16'h0, 16'h0), 4'b0001, 15'h0155, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b1);
    idle(3, 1'b0, 1'b1);
    check("collision_frame2", bus.collision, 4'b0000);

    // overlap exactly on the closing edge counts for the closing frame
    idle(5, 1'b0, 1'b0);
    step(64'd0, 4'd0, 15'h0155, 1'b0, 1'b1, 1'b0);
    step(px4(16'h0, 16'h0, 16'h8001, 16'h8002), 4'b1100, 15'h0155, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    idle(3, 1'b0, 1'b1);
    check("collision_edge", bus.collision, 4'b1100);

    // randomised traffic with periodic vsync
    for (int i = 0; i < 300; i++) begin
      rv = ((i % 60) >= 54);
      rb = rv | ($urandom_range(0, 3) == 0);
      rpx = {$urandom, $urandom};
      step(rpx, 4'($urandom), 15'($urandom), ((i % 20) == 0), rv, rb);
    end
    idle(4, 1'b0, 1'b0);

    // overlap mid-frame, then asynchronous reset discards it
    for (int i = 0; i < 3; i++)
      step(px4(16'h8111, 16'h8222, 16'h0, 16'h0), 4'b0011, 15'h0155, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++)
      step(px4(16'h0, 16'h8333, 16'h0, 16'h0), 4'b0010, 15'h0155, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b1);
    idle(4, 1'b0, 1'b1);
    check("collision_after_reset", bus.collision, 4'b0000);

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("frame_done_count", fd_seen, m_fd_cnt);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter PIXEL_SIZE, default 16, sprite/background pixel width; bit PIXEL_SIZE-1 is opaque flag (1=opaque), lower bits colour.
REQ-002 Parameter NUM_SPRITES, default 4, number of sprite layers; index 0 = highest priority.
REQ-003 Parameter SYNC_DELAY, default 2, cycles hsync/vsync/blank are delayed to align with pixel_out.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sprite_pixel  input  NUM_SPRITES*PIXEL_SIZE  packed sprite pixels, layer i at [i*PIXEL_SIZE +: PIXEL_SIZE].
REQ-007 sprite_en  input  NUM_SPRITES  per-layer d_en (sprite covers current pixel).
REQ-008 bg_pixel  input  PIXEL_SIZE-1  background colour for current pixel.
REQ-009 hsync_in, vsync_in, blank_in  input  1 each  raw timing from scan generator, issued with pixel coordinates (active-high).
REQ-010 pixel_out  output  PIXEL_SIZE-1  composited colour.
REQ-011 hsync_out, vsync_out, blank_out  output  1 each  timing delayed by SYNC_DELAY.
REQ-012 collision  output  NUM_SPRITES  per-layer collision status for last completed frame.
REQ-013 frame_done  output  1  one-cycle pulse when collision is updated.

Function
REQ-014 Layer i is visible when sprite_en[i]=1 and its opaque bit=1; otherwise transparent.
REQ-015 Winner = lowest-index visible layer; pixel_out = winner colour bits, else bg_pixel.
REQ-016 pixel_out is registered: sprite/bg inputs sampled at edge N appear at edge N+1 (latency 1).
REQ-017 Timing inputs pass through a SYNC_DELAY-deep shift register; default 2 = 1 sprite stage + 1 compositor stage.
REQ-018 pixel_out = 0 whenever the blank delayed by SYNC_DELAY-1 (aligned with sprite inputs) is 1.
REQ-019 Per-pixel hit: layer i hits when it is visible and at least one other layer is visible in the same cycle, unblanked.
REQ-020 Hits OR into a sticky hit register per layer for the current frame.
REQ-021 Frame end = rising edge of vsync_out (0 in previous cycle, 1 now).
REQ-022 On frame end: collision <= sticky | hits of that same cycle; sticky cleared to 0; frame_done=1 for exactly that cycle.
REQ-023 Simultaneous hit and frame end: the hit counts toward the frame being closed, not the next.
REQ-024 vsync held high many cycles yields exactly one frame_done; collision holds value until next frame end.
REQ-025 Single visible layer, or none, never sets a hit.
REQ-026 Internal FSM for frame tracking: ACTIVE (accumulate) -> VSYNC on frame end (hold, pulse once) -> ACTIVE on vsync_out falling.

Reset
REQ-027 On rst=1 asynchronously: pixel_out=0, hsync_out=0, vsync_out=0, blank_out=1, collision=0, frame_done=0, sticky=0, delay lines: sync bits 0, blank bits 1, FSM=ACTIVE.
REQ-028 Reset mid-frame discards partial sticky hits; first frame_done after reset occurs at first subsequent vsync rising edge seen at output.

Structure
REQ-029 Shared package holds PIXEL_SIZE default, opaque-bit index, and FSM state encoding (ACTIVE, VSYNC).
REQ-030 One sub-module: sync_delay_line (parameterised width/depth shift register with per-bit reset value) for timing alignment.
REQ-031 Priority select implemented as a loop over NUM_SPRITES; no per-layer hand-written code.

Verification
REQ-032 Layer0=0x801F en=1, layer1=0xFC00 en=1, bg=0x03E0 -> pixel_out=0x001F one cycle later; collision bits 0,1 set after next vsync edge.
REQ-033 Layer0 transparent (0x001F), layer2=0x83E0 en=1 -> pixel_out=0x03E0; no collision for layer 0.
REQ-034 blank_in=1 with opaque sprites -> pixel_out=0, no hit recorded; blank_out asserted 2 cycles after blank_in.
REQ-035 vsync_in high 10 cycles -> single frame_done pulse 2 cycles after vsync_in rise; collision cleared next frame if no overlap.
REQ-036 Overlap in same cycle as vsync_out rising edge -> reported in collision at that edge.
REQ-037 rst asserted mid-frame after overlap -> all outputs to reset values immediately; next frame_done reports collision=0.
